lsu: RTL and testbench



---
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I MEM-stage load/store unit: one req/gnt/rvalid transaction per memory op,
// with store byte-lane steering, load extraction/extension and pipeline stall.
module lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [29:0] waddr_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] ld_data_q, ld_data_d;

   logic        op, is_b, is_h, mis_cond, issue, go;

   // ---------------- issue decode ----------------
   assign op       = ex_load | ex_store;
   assign is_b     = (ex_funct3 == 3'b000) | (ex_funct3 == 3'b100);
   assign is_h     = (ex_funct3 == 3'b001) | (ex_funct3 == 3'b101);
   assign mis_cond = (is_h & ex_addr[0]) | (~is_b & ~is_h & (|ex_addr[1:0]));
   assign issue    = (state_q == S_IDLE) & ex_valid & op;
   assign go       = issue & ~mis_cond;
   assign misalign = issue & mis_cond;

   always_comb begin
      be_d = 4'b1111;
      if (ex_store) begin
         if (is_b)      be_d = 4'b0001 << ex_addr[1:0];
         else if (is_h) be_d = 4'b0011 << ex_addr[1:0];
      end
   end

   // Each lane carries the byte it would hold after replication of the store operand.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      always_comb begin
         wdata_d[8*k +: 8] = ex_wdata[8*k +: 8];
         if (is_b)      wdata_d[8*k +: 8] = ex_wdata[7:0];
         else if (is_h) wdata_d[8*k +: 8] = ex_wdata[8*(k%2) +: 8];
      end
   end

   // ---------------- load extraction ----------------
   logic [31:0] shifted;
   logic        ld_b, ld_h, ld_u;

   assign shifted = mem_rdata >> {off_q, 3'b000};
   assign ld_b    = (f3_q == 3'b000) | (f3_q == 3'b100);
   assign ld_h    = (f3_q == 3'b001) | (f3_q == 3'b101);
   assign ld_u    = f3_q[2];

   always_comb begin
      ld_data_d = shifted;
      if (ld_b)      ld_data_d = {{24{~ld_u & shifted[7]}}, shifted[7:0]};
      else if (ld_h) ld_data_d = {{16{~ld_u & shifted[15]}}, shifted[15:0]};
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (go) state_d = S_REQ;
         S_REQ:   if (mem_gnt) state_d = we_q ? S_DONE : S_WAIT;
         S_WAIT:  if (mem_rvalid) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         waddr_q   <= '0;
         off_q     <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         ld_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (go) begin
            waddr_q <= ex_addr[31:2];
            off_q   <= ex_addr[1:0];
            f3_q    <= ex_funct3;
            we_q    <= ex_store;
            be_q    <= be_d;
            wdata_q <= wdata_d;
         end
         if ((state_q == S_WAIT) && mem_rvalid) ld_data_q <= ld_data_d;
      end
   end

   // Outputs decode straight from state so reset drops mem_req/ld_valid at once.
   assign stall     = go | (state_q == S_REQ) | (state_q == S_WAIT);
   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = we_q;
   assign mem_addr  = {waddr_q, 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign ld_data   = ld_data_q;
   assign ld_valid  = (state_q == S_DONE) & ~we_q;

endmodule

// File: tb/tb_lsu.sv
// Directed + randomized bench for lsu; expectations come from a size/offset
// arithmetic model of RV32I load/store semantics.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_load, ex_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic        stall, ld_valid, misalign;
   logic [31:0] ld_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_ld = 32'h0;

   lsu dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
      return (a % m_size(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
      int s = m_size(f3);
      if (!st || s == 4) return 4'hF;
      return 4'(((1 << s) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
      case (m_size(f3))
         1:       return (d % 256) * 32'h01010101;
         2:       return (d % 65536) * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v = rd >> (8 * (a % 4));
      case (m_size(f3))
         1: begin v = v % 256;   if (f3 == 3'd0 && v >= 128)   v = v - 256;   end
         2: begin v = v % 65536; if (f3 == 3'd1 && v >= 32768) v = v - 65536; end
         default: ;
      endcase
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input int gd, input int rd, input logic [31:0] rdata);
      bit is_ld = ld & ~st;
      @(posedge clk); #1;
      ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = rs2;
      mem_gnt = 0; mem_rvalid = 0;
      @(negedge clk);
      chk("issue_stall", stall, 1);
      chk("issue_misalign", misalign, 0);
      chk("issue_req", mem_req, 0);
      for (int i = 0; i <= gd; i++) begin
         @(posedge clk); #1;
         mem_gnt = (i == gd);
         @(negedge clk);
         chk("req_high", mem_req, 1);
         chk("req_stall", stall, 1);
         chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
         chk("req_we", mem_we, st);
         chk("req_be", mem_be, m_be(st, f3, a));
         if (st) chk("req_wdata", mem_wdata, m_wd(f3, rs2));
         chk("req_ldv", ld_valid, 0);
      end
      @(posedge clk); #1;
      mem_gnt = 0;
      if (is_ld) begin
         for (int j = 0; j <= rd; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            mem_rvalid = (j == rd);
            mem_rdata  = (j == rd) ? rdata : $urandom;
            @(negedge clk);
            chk("wait_stall", stall, 1);
            chk("wait_req", mem_req, 0);
            chk("wait_ldv", ld_valid, 0);
            chk("wait_ldhold", ld_data, exp_ld);
         end
         @(posedge clk); #1;
         mem_rvalid = 0; mem_rdata = $urandom;
         exp_ld = m_ld(f3, a, rdata);
      end
      @(negedge clk);
      chk("done_stall", stall, 0);
      chk("done_ldv", ld_valid, is_ld);
      chk("done_req", mem_req, 0);
      chk("done_lddata", ld_data, exp_ld);
      @(posedge clk); #1;
      ex_valid = 0;
      @(negedge clk);
      chk("idle_stall", stall, 0);
      chk("idle_ldv", ld_valid, 0);
      chk("idle_lddata", ld_data, exp_ld);
   endtask

   task automatic misaligned(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
      @(posedge clk); #1;
      ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = $urandom;
      mem_gnt = 0; mem_rvalid = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mis_flag", misalign, 1);
         chk("mis_stall", stall, 0);
         chk("mis_req", mem_req, 0);
         @(posedge clk); #1;
      end
      ex_valid = 0;
      @(negedge clk);
      chk("mis_clear", misalign, 0);
      chk("mis_req_after", mem_req, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1; ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0;
      ex_addr = 0; ex_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      #2;
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_ldv", ld_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_lddata", ld_data, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_stall", stall, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // SW immediate grant, SB at offset 3
      access(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      access(0, 1, 3'd0, 32'h203, 32'h000000A5, 0, 0, 0);
      chk("sb_be", mem_be, 4'b1000);
      chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);

      // LB / LBU with rvalid two cycles after grant
      access(1, 0, 3'd0, 32'h12, 0, 0, 1, 32'h00800000);
      chk("lb_val", ld_data, 32'hFFFFFF80);
      access(1, 0, 3'd4, 32'h12, 0, 0, 1, 32'h00800000);
      chk("lbu_val", ld_data, 32'h00000080);
      access(1, 0, 3'd1, 32'h22, 0, 0, 0, 32'h9ABC0000);
      chk("lh_val", ld_data, 32'hFFFF9ABC);
      access(1, 0, 3'd5, 32'h22, 0, 0, 0, 32'h9ABC0000);
      chk("lhu_val", ld_data, 32'h00009ABC);

      // misaligned never reaches the bus
      misaligned(1, 0, 3'd2, 32'h102);
      misaligned(0, 1, 3'd1, 32'h101);

      // grant backpressure on a store and a load; store wins over load
      access(0, 1, 3'd1, 32'h3002, 32'h1234ABCD, 3, 0, 0);
      access(1, 0, 3'd2, 32'h4000, 0, 3, 2, 32'hCAFEF00D);
      access(1, 1, 3'd0, 32'h5001, 32'h77, 1, 0, 0);

      // reset while in REQ drops mem_req asynchronously
      @(posedge clk); #1;
      ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = 3'd2; ex_addr = 32'h40;
      @(posedge clk); #1;
      chk("rreq_req", mem_req, 1);
      ex_valid = 0; rst = 1; #1;
      chk("rreq_req_drop", mem_req, 0);
      chk("rreq_addr", mem_addr, 0);
      @(posedge clk); #1 rst = 0;
      exp_ld = 32'h0;

      // reset while in WAIT: no ld_valid ever, state back to IDLE
      @(posedge clk); #1;
      ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = 3'd2; ex_addr = 32'h80;
      @(posedge clk); #1 mem_gnt = 1;
      @(posedge clk); #1 mem_gnt = 0;
      @(negedge clk);
      chk("rwait_stall", stall, 1);
      ex_valid = 0; rst = 1; #1;
      chk("rwait_req", mem_req, 0);
      chk("rwait_ldv", ld_valid, 0);
      chk("rwait_stall0", stall, 0);
      @(posedge clk); #1 rst = 0; mem_rvalid = 1; mem_rdata = 32'h55555555;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rwait_noldv", ld_valid, 0);
         chk("rwait_lddata", ld_data, 0);
         @(posedge clk); #1 mem_rvalid = 0;
      end
      access(1, 0, 3'd2, 32'h84, 0, 0, 0, 32'h0BADBEEF);

      // randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  f3 = 3'($urandom_range(0, 7));
         int          op = $urandom_range(0, 2);
         logic [31:0] a  = $urandom;
         bit          ld = (op != 1);
         bit          st = (op != 0);
         if (m_mis(f3, a))
            misaligned(ld, st, f3, a);
         else
            access(ld, st, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
